// File: rtl/alu_responder.sv
// Single-issue 32-bit ALU with registered results. MUL runs as a 32-step
// shift-add sequence during which the unit reports busy and drops new requests.
module alu_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  alu_op_code,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic [31:0] y,
    output logic        Z,
    output logic        C,
    output logic        result_valid,
    output logic        busy,
    output logic        dropped
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    state_t      state_q, state_d;
    logic [31:0] y_q, y_d;
    logic        z_q, z_d;
    logic        c_q, c_d;
    logic        rv_q, rv_d;
    logic        busy_q, busy_d;
    logic        dropped_q, dropped_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;

    logic [32:0] sum_s;
    logic [31:0] diff_s;
    logic [31:0] step_acc_s;

    // Next-state, datapath and flag computation for both FSM states.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        z_d        = z_q;
        c_d        = c_q;
        rv_d       = 1'b0;
        busy_d     = busy_q;
        dropped_d  = 1'b0;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        sum_s      = {1'b0, data_a} + {1'b0, data_b};
        diff_s     = data_a - data_b;
        step_acc_s = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (op_valid) begin
                    case (alu_op_code)
                        OP_ADD: begin
                            y_d = sum_s[31:0]; z_d = (sum_s[31:0] == 32'd0); c_d = sum_s[32]; rv_d = 1'b1;
                        end
                        OP_SUB: begin
                            y_d = diff_s; z_d = (diff_s == 32'd0); c_d = (data_a >= data_b); rv_d = 1'b1;
                        end
                        OP_AND: begin
                            y_d = data_a & data_b; z_d = ((data_a & data_b) == 32'd0); c_d = 1'b0; rv_d = 1'b1;
                        end
                        OP_OR: begin
                            y_d = data_a | data_b; z_d = ((data_a | data_b) == 32'd0); c_d = 1'b0; rv_d = 1'b1;
                        end
                        OP_XOR: begin
                            y_d = data_a ^ data_b; z_d = ((data_a ^ data_b) == 32'd0); c_d = 1'b0; rv_d = 1'b1;
                        end
                        OP_SLL: begin
                            y_d = data_a << data_b[4:0]; z_d = ((data_a << data_b[4:0]) == 32'd0);
                            c_d = 1'b0; rv_d = 1'b1;
                        end
                        OP_MUL: begin
                            mcand_d  = data_a;
                            mplier_d = data_b;
                            acc_d    = 32'd0;
                            cnt_d    = 5'd0;
                            busy_d   = 1'b1;
                            state_d  = MUL_RUN;
                        end
                        OP_CMP: begin
                            z_d = (data_a == data_b); c_d = (data_a >= data_b); rv_d = 1'b1;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_RUN: begin
                dropped_d = op_valid;
                acc_d     = step_acc_s;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                // The count saturates at 31, where leaving MUL_RUN is unconditional.
                if (cnt_q == 5'd31) begin
                    y_d     = step_acc_s;
                    z_d     = (step_acc_s == 32'd0);
                    c_d     = 1'b0;
                    rv_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_q       <= 32'd0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            rv_q      <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
            cnt_q     <= 5'd0;
            acc_q     <= 32'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            z_q       <= z_d;
            c_q       <= c_d;
            rv_q      <= rv_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
        end
    end

    assign y            = y_q;
    assign Z            = z_q;
    assign C            = c_q;
    assign result_valid = rv_q;
    assign busy         = busy_q;
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_alu_responder.sv
// Directed and randomized checks of alu_responder against an arithmetic
// reference model of the opcode table.
module tb_alu_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  alu_op_code;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] y;
    logic        Z;
    logic        C;
    logic        result_valid;
    logic        busy;
    logic        dropped;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_y = 32'd0;
    logic        exp_z = 1'b0;
    logic        exp_c = 1'b0;

    alu_responder dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .alu_op_code(alu_op_code),
        .data_a(data_a), .data_b(data_b), .y(y), .Z(Z), .C(C),
        .result_valid(result_valid), .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on the opcode table.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned la, lb, r;
        la = longint'(a);
        lb = longint'(b);
        case (op)
            3'd0: begin r = la + lb; exp_y = r[31:0]; exp_c = (r > 64'h0000_0000_FFFF_FFFF); end
            3'd1: begin exp_y = a - b; exp_c = (la >= lb); end
            3'd2: begin exp_y = a & b; exp_c = 1'b0; end
            3'd3: begin exp_y = a | b; exp_c = 1'b0; end
            3'd4: begin exp_y = a ^ b; exp_c = 1'b0; end
            3'd5: begin exp_y = 32'(la * (64'd1 << (lb % 64'd32))); exp_c = 1'b0; end
            3'd6: begin r = la * lb; exp_y = r[31:0]; exp_c = 1'b0; end
            default: begin exp_c = (la >= lb); end
        endcase
        if (op == 3'd7) exp_z = (a == b);
        else            exp_z = (exp_y == 32'd0);
    endtask

    task automatic check_result(input string tag);
        chk32({tag, ".y"}, y, exp_y);
        chk32({tag, ".Z"}, 32'(Z), 32'(exp_z));
        chk32({tag, ".C"}, 32'(C), 32'(exp_c));
    endtask

    // Single-cycle op: inputs stay asserted afterwards so calls chain back-to-back.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        op_valid = 1'b1; alu_op_code = op; data_a = a; data_b = b;
        @(posedge clk); #1;
        model(op, a, b);
        chk32({tag, ".rv"}, 32'(result_valid), 32'd1);
        chk32({tag, ".busy"}, 32'(busy), 32'd0);
        check_result(tag);
    endtask

    task automatic idle_cycle(input string tag);
        op_valid = 1'b0;
        @(posedge clk); #1;
        chk32({tag, ".rv_idle"}, 32'(result_valid), 32'd0);
        chk32({tag, ".drop_idle"}, 32'(dropped), 32'd0);
    endtask

    // MUL with optional ADD 1,1 requests injected while busy.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int ndrop, input string tag);
        int edges, drops, busy_cnt;
        bit done;
        op_valid = 1'b1; alu_op_code = 3'd6; data_a = a; data_b = b;
        @(posedge clk); #1;
        chk32({tag, ".busy0"}, 32'(busy), 32'd1);
        chk32({tag, ".rv0"}, 32'(result_valid), 32'd0);
        edges = 0; drops = 0; busy_cnt = 1; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k >= 3 && k < 3 + ndrop) begin
                op_valid = 1'b1; alu_op_code = 3'd0; data_a = 32'd1; data_b = 32'd1;
            end else begin
                op_valid = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cnt++;
            if (dropped) drops++;
            if (result_valid) done = 1'b1;
            else if (y !== exp_y) begin
                chk32({tag, ".y_held"}, y, exp_y);
            end
        end
        op_valid = 1'b0;
        chk32({tag, ".latency"}, 32'(edges), 32'd32);
        chk32({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd32);
        chk32({tag, ".drops"}, 32'(drops), 32'(ndrop));
        chk32({tag, ".busy_end"}, 32'(busy), 32'd0);
        model(3'd6, a, b);
        check_result(tag);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int rv_seen;

        // Reset dominates a pending request.
        rst_n = 1'b0; op_valid = 1'b1; alu_op_code = 3'd0; data_a = 32'd7; data_b = 32'd9;
        repeat (2) @(posedge clk);
        #1;
        chk32("rst.y", y, 32'd0);
        chk32("rst.Z", 32'(Z), 32'd0);
        chk32("rst.C", 32'(C), 32'd0);
        chk32("rst.rv", 32'(result_valid), 32'd0);
        chk32("rst.busy", 32'(busy), 32'd0);
        chk32("rst.drop", 32'(dropped), 32'd0);

        // First edge out of reset accepts.
        rst_n = 1'b1;
        do_op(3'd0, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        chk32("add_wrap.y_const", y, 32'd0);
        chk32("add_wrap.ZC_const", {30'd0, Z, C}, 32'd3);
        idle_cycle("add_wrap");

        do_op(3'd1, 32'd5, 32'd7, "sub_borrow");
        chk32("sub_borrow.y_const", y, 32'hFFFF_FFFE);
        do_op(3'd7, 32'd9, 32'd9, "cmp_eq");
        chk32("cmp_eq.y_const", y, 32'hFFFF_FFFE);
        chk32("cmp_eq.ZC_const", {30'd0, Z, C}, 32'd3);
        do_op(3'd5, 32'd1, 32'h0000_0025, "sll");
        chk32("sll.y_const", y, 32'h0000_0020);
        idle_cycle("sll");

        run_mul(32'h0001_0001, 32'h0001_0001, 0, "mul_basic");
        chk32("mul_basic.y_const", y, 32'h0002_0001);
        // First accept possible on the edge right after result_valid.
        do_op(3'd3, 32'hF0F0_0000, 32'h0000_0F0F, "or_after_mul");
        idle_cycle("or_after_mul");

        run_mul(32'hDEAD_BEEF, 32'h1234_5678, 3, "mul_drop");
        idle_cycle("mul_drop");
        run_mul(32'd0, 32'hFFFF_FFFF, 0, "mul_zero");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
        idle_cycle("mul_max");

        // Reset in the middle of a multiply aborts it.
        op_valid = 1'b1; alu_op_code = 3'd6; data_a = 32'd3; data_b = 32'd4;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_y = 32'd0; exp_z = 1'b0; exp_c = 1'b0;
        check_result("mul_abort");
        chk32("mul_abort.busy", 32'(busy), 32'd0);
        chk32("mul_abort.rv", 32'(result_valid), 32'd0);
        rv_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (result_valid || busy) rv_seen++;
        end
        chk32("mul_abort.no_result", 32'(rv_seen), 32'd0);
        do_op(3'd0, 32'd2, 32'd3, "add_after_rst");
        chk32("add_after_rst.y_const", y, 32'd5);
        idle_cycle("add_after_rst");

        // Randomized back-to-back traffic with occasional multiplies.
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            if (rop == 3'd6) begin
                run_mul(ra, rb, int'($urandom_range(0, 2)), $sformatf("rnd%0d_mul", i));
            end else begin
                do_op(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
            end
            if ($urandom_range(0, 4) == 0) idle_cycle($sformatf("rnd%0d", i));
        end
        op_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
